// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv32_pkg
// Brief   : Shared RV32 front-end constants and fetch FSM state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package rv32_pkg;

  // addi x0, x0, 0 -- presented whenever the fetch buffer has nothing to offer
  localparam logic [31:0] c_nop_instr = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Small circular instruction buffer with push/pop/clear and count.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int                   c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                   c_CNT_W     = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0]   c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0]   c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_pop;
  logic               w_do_push;

  // Pointers wrap at DEPTH so non-power-of-two depths work too
  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_DEPTH_CNT);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Credit-limited instruction fetch with in-order imem responses,
//          redirect flush and stale-response dropping.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_en,
  input  logic        ifIdWrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  localparam int               c_CNT_W      = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W:0] c_CREDIT_MAX = (c_CNT_W + 1)'(DEPTH);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_deq_pc;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_drop_cnt;

  logic [c_CNT_W-1:0] w_buf_count;
  logic               w_buf_full;
  logic               w_buf_empty;
  logic [31:0]        w_buf_head;
  logic [c_CNT_W:0]   w_in_use;
  logic [31:0]        w_redirect_pc;
  logic               w_req_fire;
  logic               w_rsp_accepted;
  logic               w_rsp_keep;
  logic               w_consume;

  // Credit covers both in-flight requests and words already buffered
  assign w_in_use       = {1'b0, r_outstanding} + {1'b0, w_buf_count};
  assign w_redirect_pc  = redirect_pc & ~32'h0000_0003;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_accepted = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_keep     = w_rsp_accepted && (r_drop_cnt == '0) && !redirect_valid;
  assign w_consume      = if_valid && ifIdWrite && !redirect_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req_valid = fetch_en && !redirect_valid && (w_in_use < c_CREDIT_MAX);
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc    <= RESET_PC;
      r_deq_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      case ({w_req_fire, w_rsp_accepted})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      // Everything still in flight at a redirect belongs to the old path
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_deq_pc   <= w_redirect_pc;
        r_drop_cnt <= r_outstanding - c_CNT_W'(w_rsp_accepted);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_consume)  r_deq_pc   <= r_deq_pc + 32'd4;
        if (w_rsp_accepted && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fetch_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_rsp_keep),
    .i_push_data (imem_rsp_data),
    .i_pop       (w_consume),
    .i_clear     (redirect_valid),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count),
    .o_full      (w_buf_full),
    .o_empty     (w_buf_empty)
  );

  assign imem_req_addr  = r_fetch_pc;
  assign if_valid       = !w_buf_empty;
  assign if_pc          = r_deq_pc;
  assign if_instruction = w_buf_empty ? c_nop_instr : w_buf_head;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (resetn) begin
      assert (!(imem_rsp_valid && (r_outstanding == '0)))
        else $error("fetch_unit: imem response with no request outstanding");
      assert (!(w_rsp_keep && w_buf_full && !w_consume))
        else $error("fetch_unit: response pushed into a full buffer");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Randomized self-checking bench for fetch_unit with a queue-based
//          memory and program-order reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
  import rv32_pkg::*;

  localparam logic [31:0] c_RESET_PC = 32'hFFFF_FFF8;
  localparam int          c_DEPTH    = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_en;
  logic        ifIdWrite;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (c_RESET_PC),
    .DEPTH    (c_DEPTH)
  ) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .fetch_en       (fetch_en),
    .ifIdWrite      (ifIdWrite),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];        // requests accepted by memory, oldest first
  logic [31:0] bq[$];        // PCs of words the fetch buffer should hold
  logic [31:0] req_log[$];
  logic [31:0] cons_log[$];
  int          drop_n;
  logic [31:0] exp_fetch_pc;
  logic [31:0] exp_deq_pc;
  bit          started;
  int          cyc;
  int          n_checks;
  int          n_fail;

  bit          s_fetch_en, s_ifid, s_ready, s_redir, redir_on_rsp;
  logic [31:0] s_redir_pc;
  int          lat_min, lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model
  task automatic step();
    bit          rsp;
    bit          exp_rv;
    logic [31:0] exp_instr;
    mreq_t       r;
    @(negedge clk);
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    if (redir_on_rsp && rsp) begin
      s_redir      = 1'b1;
      redir_on_rsp = 1'b0;
    end
    fetch_en       = s_fetch_en;
    ifIdWrite      = s_ifid;
    imem_req_ready = s_ready;
    redirect_valid = s_redir;
    redirect_pc    = s_redir_pc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom();
    #1;
    exp_rv = started && s_fetch_en && !s_redir && ((mq.size() + bq.size()) < c_DEPTH);
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check_eq("req_addr", imem_req_addr, exp_fetch_pc);
    check_eq("if_valid", 32'(if_valid), 32'(bq.size() > 0));
    check_eq("if_pc", if_pc, exp_deq_pc);
    exp_instr = (bq.size() > 0) ? mem_word(bq[0]) : c_nop_instr;
    check_eq("if_instr", if_instruction, exp_instr);

    if (rsp) r = mq.pop_front();
    if (s_redir) begin
      bq.delete();
      drop_n       = mq.size();
      exp_fetch_pc = s_redir_pc & ~32'h3;
      exp_deq_pc   = s_redir_pc & ~32'h3;
    end else begin
      if ((bq.size() > 0) && s_ifid) begin
        cons_log.push_back(exp_deq_pc);
        void'(bq.pop_front());
        exp_deq_pc += 32'd4;
      end
      if (rsp) begin
        if (drop_n > 0) drop_n--;
        else            bq.push_back(r.addr);
      end
      if (exp_rv && s_ready) begin
        mq.push_back('{addr: exp_fetch_pc, due: cyc + int'($urandom_range(lat_max, lat_min))});
        req_log.push_back(exp_fetch_pc);
        exp_fetch_pc += 32'd4;
      end
    end
    s_redir = 1'b0;
    cyc++;
    @(posedge clk);
    started = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n, input bit late_rsp);
    @(negedge clk);
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_pc", if_pc, c_RESET_PC);
    check_eq("rst_if_instr", if_instruction, c_nop_instr);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    mq.delete();
    bq.delete();
    drop_n       = 0;
    exp_fetch_pc = c_RESET_PC;
    exp_deq_pc   = c_RESET_PC;
    started      = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      imem_rsp_valid = late_rsp;
      imem_rsp_data  = $urandom();
      #1;
      check_eq("rst_hold_valid", 32'(if_valid), 32'd0);
      check_eq("rst_hold_pc", if_pc, c_RESET_PC);
    end
    @(posedge clk);
    #2;
    imem_rsp_valid = 1'b0;
    resetn         = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nc;
    resetn = 1'b0; fetch_en = 1'b0; ifIdWrite = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    n_checks = 0; n_fail = 0; cyc = 0; drop_n = 0; started = 1'b0;
    s_fetch_en = 1'b0; s_ifid = 1'b0; s_ready = 1'b0; s_redir = 1'b0; redir_on_rsp = 1'b0;
    s_redir_pc = '0; lat_min = 1; lat_max = 1;
    exp_fetch_pc = c_RESET_PC; exp_deq_pc = c_RESET_PC;

    // Streaming from reset, addresses wrap through zero
    do_reset(3, 1'b0);
    s_fetch_en = 1'b1; s_ifid = 1'b1; s_ready = 1'b1;
    run(12);
    check_eq("first_req0", req_log[0], 32'hFFFF_FFF8);
    check_eq("first_req1", req_log[1], 32'hFFFF_FFFC);
    check_eq("first_req2", req_log[2], 32'h0000_0000);
    check_eq("first_out0", cons_log[0], 32'hFFFF_FFF8);
    check_eq("first_out2", cons_log[2], 32'h0000_0000);

    // Stall from an empty pipe: only two requests fit
    s_fetch_en = 1'b0;
    run(6);
    s_fetch_en = 1'b1; s_ifid = 1'b0;
    n = req_log.size();
    run(5);
    check_eq("stall_reqs", req_log.size() - n, 32'd2);
    s_ifid = 1'b1;
    run(8);

    // Redirect with two requests outstanding
    s_fetch_en = 1'b0;
    run(8);
    s_fetch_en = 1'b1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq.size() < 2; i++) step();
    check_eq("redir_setup", mq.size(), 32'd2);
    s_redir = 1'b1; s_redir_pc = 32'h0000_0100;
    nc = cons_log.size();
    step();
    run(14);
    check_eq("redir_first_pc", cons_log[nc], 32'h0000_0100);
    check_eq("redir_second_pc", cons_log[nc + 1], 32'h0000_0104);

    // Redirect coinciding with a response, unaligned target
    lat_min = 2; lat_max = 2;
    s_redir_pc = 32'h0000_0203; redir_on_rsp = 1'b1;
    for (int i = 0; i < 20 && redir_on_rsp; i++) step();
    check_eq("rsp_redir_seen", 32'(redir_on_rsp), 32'd0);
    n = req_log.size(); nc = cons_log.size();
    run(10);
    check_eq("restart_0x200", req_log[n], 32'h0000_0200);
    check_eq("consume_0x200", cons_log[nc], 32'h0000_0200);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      s_fetch_en = ($urandom() % 10) != 0;
      s_ifid     = ($urandom() % 10) < 7;
      s_ready    = ($urandom() % 10) < 7;
      s_redir    = ($urandom() % 32) == 0;
      s_redir_pc = $urandom();
      step();
    end

    // Reset with one request in flight; late response lands during reset
    s_fetch_en = 1'b0; s_ifid = 1'b1; s_ready = 1'b1;
    run(12);
    lat_min = 4; lat_max = 4; s_fetch_en = 1'b1;
    for (int i = 0; i < 10 && mq.size() < 1; i++) step();
    check_eq("rst_setup", mq.size(), 32'd1);
    do_reset(2, 1'b1);
    lat_min = 1; lat_max = 1;
    n = req_log.size(); nc = cons_log.size();
    run(10);
    check_eq("rst_restart_req", req_log[n], c_RESET_PC);
    check_eq("rst_restart_out", cons_log[nc], c_RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
